// File: rtl/mux_3_1_pkg.sv
// Shared select-code definitions for the registered 4:1 selector.
package mux_3_1_pkg;

    // Two-bit select code, {sel0, sel1} with sel0 as the MSB.
    typedef logic [1:0] sel_t;

    localparam sel_t SEL_I0 = 2'b00;
    localparam sel_t SEL_I1 = 2'b01;
    localparam sel_t SEL_I2 = 2'b10;
    localparam sel_t SEL_I3 = 2'b11;

endpackage

// File: rtl/mux4_core.sv
// Combinational WIDTH-bit 4:1 selector. An unknown select code drives all-X
// rather than falling back to any input, so a bad select is visible in sim.
module mux4_core
    import mux_3_1_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  sel_t             sel,
    input  logic [WIDTH-1:0] i0,
    input  logic [WIDTH-1:0] i1,
    input  logic [WIDTH-1:0] i2,
    input  logic [WIDTH-1:0] i3,
    output logic [WIDTH-1:0] y
);

    // Pick the input named by the select code; no priority between codes.
    always_comb begin
        case (sel)
            SEL_I0:  y = i0;
            SEL_I1:  y = i1;
            SEL_I2:  y = i2;
            SEL_I3:  y = i3;
            default: y = 'x;
        endcase
    end

endmodule

// File: rtl/mux_3_1.sv
// Registered 4:1 selector: combinational output for same-cycle consumers and
// a registered copy (with the select code that produced it) for timing-closed
// consumers.
module mux_3_1
    import mux_3_1_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sel0,
    input  logic             sel1,
    input  logic [WIDTH-1:0] i0,
    input  logic [WIDTH-1:0] i1,
    input  logic [WIDTH-1:0] i2,
    input  logic [WIDTH-1:0] i3,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] y_q,
    output logic [1:0]       sel_q
);

    sel_t sel;

    assign sel = {sel0, sel1};

    mux4_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .sel (sel),
        .i0  (i0),
        .i1  (i1),
        .i2  (i2),
        .i3  (i3),
        .y   (y)
    );

    // Capture the selected data and its select code together; reset wins over enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            y_q   <= '0;
            sel_q <= SEL_I0;
        end else if (en) begin
            y_q   <= y;
            sel_q <= sel;
        end
    end

endmodule

// File: tb/tb_mux_3_1.sv
// Directed bench for mux_3_1: one 1-bit and one 8-bit instance share clock,
// reset, enable and selects. A high-level model (array lookup plus a captured
// copy) is compared every cycle; literal checks pin the model itself.
module tb_mux_3_1;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       sel0;
    logic       sel1;
    logic [3:0] nib;          // {i3,i2,i1,i0} for the 1-bit instance
    logic [7:0] a8 [4];       // i0..i3 for the 8-bit instance

    logic       y1, yq1;
    logic [1:0] sq1;
    logic [7:0] y8, yq8;
    logic [1:0] sq8;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    mux_3_1 #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .en(en), .sel0(sel0), .sel1(sel1),
        .i0(nib[0]), .i1(nib[1]), .i2(nib[2]), .i3(nib[3]),
        .y(y1), .y_q(yq1), .sel_q(sq1)
    );

    mux_3_1 #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .en(en), .sel0(sel0), .sel1(sel1),
        .i0(a8[0]), .i1(a8[1]), .i2(a8[2]), .i3(a8[3]),
        .y(y8), .y_q(yq8), .sel_q(sq8)
    );

    // Behavioural model: the selected value is simply the input indexed by the
    // select number; the registered copy is what that was at the last enabled edge.
    logic [1:0] m_sel_q;
    logic       m_yq1;
    logic [7:0] m_yq8;
    bit         m_valid = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_yq1   <= 1'b0;
            m_yq8   <= 8'h00;
            m_sel_q <= 2'd0;
            m_valid <= 1'b1;
        end else if (en) begin
            m_yq1   <= nib[{sel0, sel1}];
            m_yq8   <= a8[{sel0, sel1}];
            m_sel_q <= {sel0, sel1};
        end
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (m_valid) begin
            chk("model y1",    {7'd0, y1},  {7'd0, nib[{sel0, sel1}]});
            chk("model y8",    y8,          a8[{sel0, sel1}]);
            chk("model yq1",   {7'd0, yq1}, {7'd0, m_yq1});
            chk("model yq8",   yq8,         m_yq8);
            chk("model selq1", {6'd0, sq1}, {6'd0, m_sel_q});
            chk("model selq8", {6'd0, sq8}, {6'd0, m_sel_q});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_sel(input logic [1:0] s);
        sel0 = s[1];
        sel1 = s[0];
    endtask

    logic [0:3] exp_sweep;

    initial begin
        rst = 1'b1;
        en  = 1'b1;
        set_sel(2'b11);
        nib = 4'h5;
        a8[0] = 8'hA1; a8[1] = 8'hB2; a8[2] = 8'hC3; a8[3] = 8'hD4;

        // Reset held for two cycles with enable asserted.
        tick();
        chk("rst yq1", {7'd0, yq1}, 8'h00);
        chk("rst selq", {6'd0, sq1}, 8'h00);
        chk("rst y8 tracks", y8, 8'hD4);
        tick();
        chk("rst yq8", yq8, 8'h00);
        #1;
        rst = 1'b0;

        // Select sweep on {i3,i2,i1,i0} = 4'h5.
        exp_sweep = 4'b1010;
        for (int s = 0; s < 4; s++) begin
            set_sel(2'(s));
            #1;
            chk("sweep y", {7'd0, y1}, {7'd0, exp_sweep[s]});
            tick();
            chk("sweep yq", {7'd0, yq1}, {7'd0, exp_sweep[s]});
            chk("sweep selq", {6'd0, sq1}, 8'(s));
        end

        // 8-bit selection of i2.
        set_sel(2'b10);
        #1;
        chk("w8 y", y8, 8'hC3);
        tick();
        chk("w8 yq", yq8, 8'hC3);
        chk("w8 selq", {6'd0, sq8}, 8'h02);

        // Mid-stream reset with enable held high.
        rst = 1'b1;
        set_sel(2'b11);
        tick();
        chk("mid rst yq8", yq8, 8'h00);
        chk("mid rst selq", {6'd0, sq8}, 8'h00);
        chk("mid rst y8", y8, 8'hD4);
        tick();
        rst = 1'b0;

        // Capture i1, then freeze with enable low while selects and data move.
        set_sel(2'b01);
        tick();
        chk("cap yq8", yq8, 8'hB2);
        en = 1'b0;
        for (int c = 0; c < 4; c++) begin
            set_sel(2'(c + 2));
            a8[1] = a8[1] + 8'h11;
            nib   = ~nib;
            tick();
            chk("hold yq8", yq8, 8'hB2);
            chk("hold selq", {6'd0, sq8}, 8'h01);
        end
        a8[1] = 8'hB2;
        nib   = 4'h5;
        en    = 1'b1;
        set_sel(2'b00);
        tick();
        chk("reen yq8", yq8, 8'hA1);
        chk("reen selq", {6'd0, sq8}, 8'h00);

        // Select and data change together: sel 01 -> 11 with i3 0 -> 1.
        nib = 4'b0001;
        set_sel(2'b01);
        tick();
        chk("pre yq1", {7'd0, yq1}, 8'h00);
        nib = 4'b1001;
        set_sel(2'b11);
        tick();
        chk("joint yq1", {7'd0, yq1}, 8'h01);
        chk("joint selq", {6'd0, sq1}, 8'h03);

        // sel = 00 while the other inputs toggle: output stays i0.
        set_sel(2'b00);
        nib = 4'b0001;
        for (int c = 0; c < 4; c++) begin
            nib[3:1] = (c % 2 == 0) ? 3'b111 : 3'b000;
            #1;
            chk("i0 y1", {7'd0, y1}, 8'h01);
            tick();
            chk("i0 yq1", {7'd0, yq1}, 8'h01);
        end

        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Guard against a stalled run.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule
